// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/freeze controller.
package pipeline_ctrl_pkg;

  localparam int unsigned REG_IDX_W  = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;
  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } sram_state_t;

  // A source depends on a producer only if the producer writes back to that nonzero register.
  function automatic logic reg_match(input logic [REG_IDX_W-1:0] src,
                                     input logic [REG_IDX_W-1:0] dest,
                                     input logic                 wb_en);
    return wb_en && (src != REG_ZERO) && (src == dest);
  endfunction

endpackage

// File: rtl/raw_hazard_detect.sv
// Combinational RAW hazard comparators for the ID stage.
// PIPE_FORWARD_EN selects the load-use-only variant used alongside a forwarding unit.
module raw_hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_src1,
  input  logic [REG_IDX_W-1:0] id_src2,
  input  logic                 id_uses_src2,
  input  logic [REG_IDX_W-1:0] exe_dest,
  input  logic                 exe_wb_en,
  input  logic                 exe_mem_r_en,
  input  logic [REG_IDX_W-1:0] mem_dest,
  input  logic                 mem_wb_en,
  output logic                 haz_raw
);

  logic src1_haz;
  logic src2_haz;

`ifdef PIPE_FORWARD_EN
  logic unused_mem;
  assign unused_mem = ^{mem_dest, mem_wb_en};

  // Forwarding covers everything except a load result needed in the very next cycle.
  always_comb begin
    src1_haz = reg_match(id_src1, exe_dest, exe_wb_en & exe_mem_r_en);
    src2_haz = id_uses_src2 & reg_match(id_src2, exe_dest, exe_wb_en & exe_mem_r_en);
  end
`else
  logic unused_ld;
  assign unused_ld = exe_mem_r_en;

  always_comb begin
    src1_haz = reg_match(id_src1, exe_dest, exe_wb_en) |
               reg_match(id_src1, mem_dest, mem_wb_en);
    src2_haz = id_uses_src2 & (reg_match(id_src2, exe_dest, exe_wb_en) |
                               reg_match(id_src2, mem_dest, mem_wb_en));
  end
`endif

  assign haz_raw = src1_haz | src2_haz;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/freeze controller: RAW hazard stalls, multi-cycle SRAM sequencing, statistics.
// Optional PIPE_FORWARD_EN restricts hazard stalls to load-use.
module pipeline_stall_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned SRAM_WAIT_CYCLES = 5,
  parameter int unsigned CNT_W            = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_src1,
  input  logic [REG_IDX_W-1:0] id_src2,
  input  logic                 id_uses_src2,
  input  logic [REG_IDX_W-1:0] exe_dest,
  input  logic                 exe_wb_en,
  input  logic                 exe_mem_r_en,
  input  logic [REG_IDX_W-1:0] mem_dest,
  input  logic                 mem_wb_en,
  input  logic                 mem_r_en,
  input  logic                 mem_w_en,
  output logic                 hold_if_id,
  output logic                 bubble_id_exe,
  output logic                 freeze_all,
  output logic                 sram_we,
  output logic                 sram_oe,
  output logic                 mem_ready,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     freeze_cnt
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(SRAM_WAIT_CYCLES - 1);

  sram_state_t           state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]      freeze_cnt_q, freeze_cnt_d;

  logic haz_raw;
  logic mem_req;
  logic freeze_raw, ready_raw, we_raw, oe_raw;

  raw_hazard_detect u_haz (
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_uses_src2 (id_uses_src2),
    .exe_dest     (exe_dest),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .haz_raw      (haz_raw)
  );

  assign mem_req = mem_r_en | mem_w_en;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    freeze_raw = 1'b0;
    ready_raw  = 1'b0;
    we_raw     = 1'b0;
    oe_raw     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_req) begin
          freeze_raw = 1'b1;
          we_raw     = mem_w_en;
          oe_raw     = mem_r_en;
          wait_d     = WAIT_LOAD;
          state_d    = (SRAM_WAIT_CYCLES == 1) ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        freeze_raw = 1'b1;
        we_raw     = mem_w_en;
        oe_raw     = mem_r_en;
        wait_d     = wait_q - WAIT_CNT_W'(1);
        if (wait_q <= WAIT_CNT_W'(1)) begin
          wait_d  = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        // Pipeline advances this cycle; a still-visible request belongs to the finished access.
        ready_raw = 1'b1;
        oe_raw    = mem_r_en;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign freeze_all    = freeze_raw & ~rst;
  assign mem_ready     = ready_raw & ~rst;
  assign sram_we       = we_raw & ~rst;
  assign sram_oe       = oe_raw & ~rst;
  assign hold_if_id    = haz_raw & ~freeze_raw & ~rst;
  assign bubble_id_exe = hold_if_id;
  assign stall_cnt     = rst ? '0 : stall_cnt_q;
  assign freeze_cnt    = rst ? '0 : freeze_cnt_q;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    freeze_cnt_d = freeze_cnt_q;
    if (hold_if_id && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (freeze_all && (freeze_cnt_q != '1))
      freeze_cnt_d = freeze_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wait_q       <= '0;
      stall_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      stall_cnt_q  <= stall_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios then random stimulus vs. a behavioural model.
module tb_pipeline_stall_ctrl;

  localparam int unsigned W       = 5;
  localparam int unsigned CW      = 6;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_src1, id_src2, exe_dest, mem_dest;
  logic          id_uses_src2, exe_wb_en, exe_mem_r_en, mem_wb_en, mem_r_en, mem_w_en;
  logic          hold_if_id, bubble_id_exe, freeze_all, sram_we, sram_oe, mem_ready;
  logic [CW-1:0] stall_cnt, freeze_cnt;

  int n_pass  = 0;
  int n_total = 0;

  // Model: an access is described by its age in cycles since the request was first seen.
  bit          m_busy = 1'b0;
  int unsigned m_age  = 0;
  int unsigned m_scnt = 0;
  int unsigned m_fcnt = 0;

  pipeline_stall_ctrl #(.SRAM_WAIT_CYCLES(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_uses_src2(id_uses_src2),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .hold_if_id(hold_if_id), .bubble_id_exe(bubble_id_exe), .freeze_all(freeze_all),
    .sram_we(sram_we), .sram_oe(sram_oe), .mem_ready(mem_ready),
    .stall_cnt(stall_cnt), .freeze_cnt(freeze_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit ref_haz();
    int unsigned writers[$];
`ifdef PIPE_FORWARD_EN
    if (exe_wb_en && exe_mem_r_en) writers.push_back(int'(exe_dest));
`else
    if (exe_wb_en) writers.push_back(int'(exe_dest));
    if (mem_wb_en) writers.push_back(int'(mem_dest));
`endif
    foreach (writers[i])
      if (writers[i] != 0 &&
          (writers[i] == id_src1 || (id_uses_src2 && writers[i] == id_src2)))
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clr_in();
    id_src1 = '0; id_src2 = '0; id_uses_src2 = 1'b0;
    exe_dest = '0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
    mem_dest = '0; mem_wb_en = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
  endtask

  task automatic tick(input string tag);
    bit req, e_frz, e_rdy, e_we, e_oe, e_hold;
    int unsigned e_s, e_f;
    req = mem_r_en | mem_w_en;
    if (!m_busy) begin
      e_frz = req; e_rdy = 1'b0; e_we = req & mem_w_en; e_oe = req & mem_r_en;
    end else begin
      e_frz = (m_age < W);
      e_rdy = (m_age == W);
      e_we  = mem_w_en && (m_age < W);
      e_oe  = mem_r_en && (m_age <= W);
    end
    e_hold = ref_haz() && !e_frz;
    e_s = m_scnt; e_f = m_fcnt;
    if (rst) begin
      e_frz = 0; e_rdy = 0; e_we = 0; e_oe = 0; e_hold = 0; e_s = 0; e_f = 0;
    end
    @(negedge clk);
    chk({tag, ".hold"},   32'(hold_if_id),    32'(e_hold));
    chk({tag, ".bubble"}, 32'(bubble_id_exe), 32'(e_hold));
    chk({tag, ".freeze"}, 32'(freeze_all),    32'(e_frz));
    chk({tag, ".ready"},  32'(mem_ready),     32'(e_rdy));
    chk({tag, ".we"},     32'(sram_we),       32'(e_we));
    chk({tag, ".oe"},     32'(sram_oe),       32'(e_oe));
    chk({tag, ".scnt"},   32'(stall_cnt),     e_s);
    chk({tag, ".fcnt"},   32'(freeze_cnt),    e_f);
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_age = 0; m_scnt = 0; m_fcnt = 0;
    end else begin
      if (e_hold && m_scnt < CNT_MAX) m_scnt++;
      if (e_frz && m_fcnt < CNT_MAX) m_fcnt++;
      if (!m_busy) begin
        if (req) begin m_busy = 1; m_age = 1; end
      end else if (m_age == W) begin
        m_busy = 0;
      end else begin
        m_age++;
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clr_in();
    @(posedge clk); #1;
    // Reset with a hazard and a request present: everything must read 0.
    exe_dest = 5'd3; exe_wb_en = 1; exe_mem_r_en = 1; id_src1 = 5'd3; mem_r_en = 1;
    tick("rst0"); tick("rst1");
    rst = 1'b0; clr_in();
    tick("idle");

    exe_dest = 5'd3; exe_wb_en = 1; exe_mem_r_en = 1; id_src1 = 5'd3;
    tick("loaduse");
    clr_in(); tick("loaduse_clr");

    mem_dest = 5'd7; mem_wb_en = 1; id_src2 = 5'd7; id_uses_src2 = 1;
    tick("memsrc2");
    id_uses_src2 = 0; tick("memsrc2_unused");
    id_uses_src2 = 1; mem_dest = 5'd0; id_src2 = 5'd0; tick("memsrc2_r0");
    clr_in(); tick("memsrc2_clr");

    mem_r_en = 1;
    repeat (W + 1) tick("sram_rd");
    clr_in(); tick("sram_rd_clr"); tick("sram_rd_clr2");

    mem_w_en = 1; exe_dest = 5'd4; exe_wb_en = 1; exe_mem_r_en = 1; id_src1 = 5'd4;
    repeat (W + 1) tick("frz_haz");
    mem_w_en = 0; tick("frz_haz_after");
    clr_in(); tick("frz_haz_clr");

    mem_r_en = 1;
    tick("rstacc_req"); tick("rstacc_a1");
    rst = 1; tick("rstacc_rst");
    rst = 0;
    repeat (W + 2) tick("rstacc_restart");
    clr_in(); tick("rstacc_clr");

    mem_w_en = 1;
    repeat (W + 1) tick("b2b_st");
    mem_w_en = 0; mem_r_en = 1;
    repeat (W + 1) tick("b2b_ld");
    clr_in(); tick("b2b_clr");

    for (int i = 0; i < 400; i++) begin
      rst          = ($urandom_range(0, 59) == 0);
      id_src1      = 5'($urandom_range(0, 3));
      id_src2      = 5'($urandom_range(0, 3));
      id_uses_src2 = 1'($urandom);
      exe_dest     = 5'($urandom_range(0, 3));
      exe_wb_en    = 1'($urandom);
      exe_mem_r_en = 1'($urandom);
      mem_dest     = 5'($urandom_range(0, 3));
      mem_wb_en    = 1'($urandom);
      mem_r_en     = ($urandom_range(0, 3) == 0);
      mem_w_en     = ($urandom_range(0, 5) == 0);
      tick("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

- Central stall/freeze controller for the 5-stage pipeline.
- Detects RAW hazards at ID that forwarding cannot cover:
  - asserts `hold_if_id` to freeze PC and IF/ID;
  - asserts `bubble_id_exe` to inject a NOP into ID/EXE.
- Sequences multi-cycle data-SRAM accesses in MEM and freezes the whole pipeline while the SRAM is busy.
- Keeps saturating stall/freeze statistics counters.

## Interface
Parameters:
- `SRAM_WAIT_CYCLES`, 5: SRAM access length in cycles; legal range 1..15.
- `CNT_W`, 32: width of each statistics counter.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  pipeline clock.
- `rst`  in  1  synchronous, active-high reset.
- `id_src1`, `id_src2`  in  5 each  source register indices of the ID-stage instruction.
- `id_uses_src2`  in  1  src2 is read as a register (R-type, store, BNE).
- `exe_dest`  in  5  destination register of the instruction in EXE.
- `exe_wb_en`  in  1  EXE instruction writes back.
- `exe_mem_r_en`  in  1  EXE instruction is a load.
- `mem_dest`  in  5  destination register of the instruction in MEM.
- `mem_wb_en`  in  1  MEM instruction writes back.
- `mem_r_en`, `mem_w_en`  in  1 each  MEM instruction is a load / store.
- `hold_if_id`  out  1  freeze PC and IF/ID.
- `bubble_id_exe`  out  1  load a NOP into ID/EXE.
- `freeze_all`  out  1  freeze every pipeline register.
- `sram_we`, `sram_oe`  out  1 each  SRAM write / output enables.
- `mem_ready`  out  1  one-cycle pulse: SRAM access complete, read data valid.
- `stall_cnt`, `freeze_cnt`  out  `CNT_W` each  cycles with `hold_if_id` / `freeze_all` high.

## Operation
Hazard detection (combinational):
- Register 0 never hazards.
- src2 is compared only when `id_uses_src2` = 1.
- `haz_raw` = any compared source equals `exe_dest` (with `exe_wb_en`) or `mem_dest` (with `mem_wb_en`).
- `hold_if_id` = `bubble_id_exe` = `haz_raw` & ~`freeze_all`.

SRAM FSM:
- IDLE:
  - `mem_req` = `mem_r_en` | `mem_w_en`.
  - If `mem_req`: load the wait counter with `SRAM_WAIT_CYCLES-1` and go to ACCESS.
  - `freeze_all` = `mem_req`, so the request cycle itself is frozen.
- ACCESS:
  - `freeze_all` = 1.
  - Counter decrements each cycle; at 0 go to DONE.
- DONE:
  - `freeze_all` = 0, `mem_ready` = 1; the pipeline advances at the end of this cycle.
  - Always returns to IDLE; a request still visible in DONE is never restarted.
  - With `SRAM_WAIT_CYCLES` = 1, IDLE goes straight to DONE.

SRAM enables:
- `sram_we` = `mem_w_en` during the request cycle and ACCESS.
- `sram_oe` = `mem_r_en` during the request cycle, ACCESS and DONE.

Priority and counters:
- `freeze_all` dominates: hazard outputs are 0 whenever `freeze_all` = 1.
- `stall_cnt` / `freeze_cnt` increment on cycles their signal is high and saturate at all-ones.

## Timing
- Reset: state IDLE, wait counter 0, both statistics counters 0.
  - While `rst` is high, all outputs are forced to 0 regardless of inputs.
- Reset mid-access: the access is abandoned and there is no `mem_ready`. The FSM is in IDLE the cycle after `rst` falls and re-evaluates `mem_req`.
- Access latency: request first visible in MEM at cycle t:
  - `freeze_all` high for cycles t..t+W-1, where W = `SRAM_WAIT_CYCLES`;
  - `mem_ready` high in cycle t+W;
  - MEM occupied for W+1 cycles total.
- Back-to-back memory instructions: the second request is seen in IDLE at t+W+1, with no gap cycle.
- Hazard outputs depend on the current stage inputs with zero latency; the stall lasts until the producer clears the compared stages.
- Counters update on the rising edge after the counted cycle.

## Configuration
- `PIPE_FORWARD_EN` defined:
  - the MEM-stage comparison is removed;
  - an EXE match hazards only if `exe_mem_r_en` = 1 (load-use);
  - result: 1-cycle stall per load-use, all other RAW handled by the forwarding unit.
- Undefined:
  - full RAW rule as in Operation;
  - an EXE match stalls 2 cycles, a MEM match 1 cycle.

## Structure
- Shared package `pipeline_ctrl_pkg`:
  - `REG_IDX_W` = 5, `REG_ZERO` = 0;
  - FSM state enum `sram_state_t` {IDLE, ACCESS, DONE};
  - wait-counter width constant.
- One sub-module, `raw_hazard_detect`: purely combinational comparators, including the `PIPE_FORWARD_EN` variant.
- FSM, SRAM enables and statistics counters live in the top level.

## Test plan
- Load-use, forwarding on: `exe_dest`=3, `exe_wb_en`=1, `exe_mem_r_en`=1, `id_src1`=3 -> `hold_if_id`=`bubble_id_exe`=1 for exactly 1 cycle, `stall_cnt`=1.
- Forwarding off: `mem_dest`=7, `mem_wb_en`=1, `id_src2`=7, `id_uses_src2`=1 -> 1-cycle stall.
  - Same stimulus with `id_uses_src2`=0 -> no stall.
  - Same stimulus with `dest`=0 -> no stall.
- SRAM read, W=5: `mem_r_en` at cycle 10 -> `freeze_all` high cycles 10-14, `mem_ready` at 15, `sram_oe` high 10-15, `freeze_cnt`=5.
- Hazard during freeze: load-use condition present during an SRAM store -> hazard outputs 0 until DONE, then stall asserts.
- Reset at ACCESS cycle 2 -> no `mem_ready`, FSM in IDLE, counters 0; a held request restarts a full W-cycle access.
- Back-to-back store then load -> `mem_ready` pulses exactly W+1 cycles apart, with no retriggered access in DONE.
